rdy_ack_word_serializer: RTL and testbench
==========================================

# rdy_ack_word_serializer

Converts multi-byte words into a byte stream over the team's rdy/ack handshake. It accepts one wide word per handshake on its input side as the responder, then drives the bytes out LSB-first as the initiator on its output side, flagging the final byte. It sits in front of `shift_reg_fifo_rdy_ack` or `cdc_reg_fifo` input ports, which consume the byte stream it produces.

## Interface
Parameters:
- `BW_M1`, default 7: byte width minus 1.
- `NB_M1`, default 3: bytes per input word minus 1.
- `CW_M1`, default 1: byte-count width minus 1, equal to ceil(log2(NB_M1+1))-1.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `i_rdy`, input, 1: upstream word valid.
- `i_ack`, output, 1: block can accept a word this cycle.
- `i_data`, input, (NB_M1+1)*(BW_M1+1): word; byte k = `i_data[k*(BW_M1+1) +: BW_M1+1]`.
- `i_cnt_m1`, input, CW_M1+1: number of valid bytes in the word minus 1.
- `o_rdy`, output, 1: output byte valid.
- `o_ack`, input, 1: downstream accepts the byte.
- `o_data`, output, BW_M1+1: current byte.
- `o_last`, output, 1: current byte is the last byte of its word.
- `busy`, output, 1: equals `o_rdy`.

## Operation
- Handshake terms:
  - `i_deal = i_rdy & i_ack`.
  - `o_deal = o_rdy & o_ack`.
  - `i_ack = !o_rdy | (o_ack & o_last)`, combinational.
- States are encoded by `o_rdy`:
  - IDLE (`o_rdy`=0): `i_ack`=1.
  - SEND (`o_rdy`=1).
- IDLE with `i_deal`:
  - register the word into a shift register and set `rem = min(i_cnt_m1, NB_M1)`;
  - next cycle: `o_data` = byte 0, `o_last = (rem==0)`, `o_rdy`=1, state goes to SEND.
- SEND with `o_deal` and `!o_last`:
  - shift the register down one byte; `o_data` = next byte;
  - `rem` decrements; `o_last` goes to 1 when `rem` reaches 0.
- SEND with `o_deal` and `o_last`:
  - if `i_deal` in the same cycle, load the new word as in IDLE, with no bubble;
  - otherwise `o_rdy` goes to 0, state goes to IDLE.
- SEND without `o_ack`: `o_data`, `o_last` and `rem` hold.
- Clamp: `i_cnt_m1` > NB_M1 is treated as NB_M1.
- Unused upper bytes of `i_data` are ignored and never emitted.
- `i_data` and `i_cnt_m1` are sampled only on `i_deal`; they are don't-care otherwise.

## Timing
- Reset values:
  - `o_rdy`=0, `o_last`=0, `o_data`=0, `busy`=0;
  - `i_ack`=1 combinationally while in reset and after release;
  - internal shift register and `rem` are 0.
- Latency: 1 cycle from the `i_deal` edge to `o_rdy`=1 carrying byte 0.
- Throughput:
  - with `o_ack` held high, one byte per cycle;
  - a word of k bytes occupies exactly k SEND cycles;
  - back-to-back words have zero idle cycles.
- `o_data` and `o_last` are registered outputs and stay stable while `o_rdy & !o_ack`.
- `i_ack` depends combinationally on `o_ack` and `o_last`. Upstream must not make `i_rdy` depend on `i_ack`.
- `o_rdy` never drops without `o_deal` on the last byte.
- Asserting `rst_n` mid-word discards the remainder of that word immediately; the state after reset is IDLE.

## Test plan
1. Reset, then `i_rdy`=1, `i_data`=0x44332211, `i_cnt_m1`=3, `o_ack`=1:
   - `i_ack`=1 on cycle 0;
   - `o_data` = 0x11, 0x22, 0x33, 0x44 on cycles 1-4;
   - `o_last`=1 only on cycle 4;
   - `o_rdy`=0 on cycle 5.
2. Short words with `o_ack`=1:
   - `i_cnt_m1`=0, `i_data`=0x000000AB → single byte 0xAB with `o_last`=1;
   - `i_cnt_m1`=1 → two bytes; the upper bytes of `i_data` never appear.
3. Back-to-back: words 0x04030201 then 0x08070605, `i_rdy` held, `o_ack`=1:
   - `o_data` = 0x01…0x08 on 8 consecutive cycles with no gap;
   - `i_ack`=1 exactly on the cycle 0x04 is acked.
4. Backpressure: `o_ack` toggles 1,0,0,1,0,1…:
   - `o_data`/`o_last` hold during the 0 cycles;
   - `i_ack`=0 throughout SEND until the last-byte deal;
   - the byte sequence is unchanged.
5. Clamp with NB_M1=3: `i_cnt_m1`=3 is the maximum. Drive an instance with CW_M1=2 and `i_cnt_m1`=6 → exactly 4 bytes are emitted.
6. Reset mid-word: pulse `rst_n` low after byte 1 of a 4-byte word → `o_rdy`=0 and `o_data`=0 immediately; the next word starts cleanly from its byte 0.
7. Randomized: random `i_rdy`/`o_ack` over 1000 words, with the scoreboard reassembling bytes via `o_last` → all words match.

Source files
------------

// File: rtl/rdy_ack_word_serializer.sv
// rdy_ack_word_serializer
//   Accepts one multi-byte word per rdy/ack handshake on the input side and
//   replays it LSB-first as a byte stream on the output side, marking the
//   final byte of each word with o_last.
//
// Parameters
//   BW_M1  byte width minus 1
//   NB_M1  bytes per input word minus 1
//   CW_M1  byte-count width minus 1 (ceil(log2(NB_M1+1))-1)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   i_rdy     upstream word valid
//   i_ack     block can accept a word this cycle (combinational)
//   i_data    input word, byte k at [k*(BW_M1+1) +: BW_M1+1]
//   i_cnt_m1  valid bytes in the word minus 1 (clamped to NB_M1)
//   o_rdy     output byte valid
//   o_ack     downstream accepts the byte
//   o_data    current byte (registered)
//   o_last    current byte is the last of its word (registered)
//   busy      same as o_rdy
module rdy_ack_word_serializer #(
   parameter int BW_M1 = 7,
   parameter int NB_M1 = 3,
   parameter int CW_M1 = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_rdy,
   output logic                           i_ack,
   input  logic [(NB_M1+1)*(BW_M1+1)-1:0] i_data,
   input  logic [CW_M1:0]                 i_cnt_m1,
   output logic                           o_rdy,
   input  logic                           o_ack,
   output logic [BW_M1:0]                 o_data,
   output logic                           o_last,
   output logic                           busy
);

   localparam int BW = BW_M1 + 1;
   localparam int NB = NB_M1 + 1;
   localparam int WW = BW * NB;
   localparam logic [CW_M1:0] REM_MAX = (CW_M1+1)'(NB_M1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   shreg_q, shreg_d;
   logic [CW_M1:0]  rem_q,   rem_d;
   logic            last_q,  last_d;

   logic            i_deal;
   logic            o_deal;
   logic [CW_M1:0]  cnt_clamped;

   assign o_rdy  = (state_q == SEND);
   assign busy   = o_rdy;
   assign o_data = shreg_q[BW-1:0];
   assign o_last = last_q;

   // Accepting a new word is allowed while idle, or in the very cycle the
   // last byte of the current word is taken, which removes the bubble.
   assign i_ack  = !o_rdy | (o_ack & last_q);
   assign i_deal = i_rdy & i_ack;
   assign o_deal = o_rdy & o_ack;

   assign cnt_clamped = (i_cnt_m1 > REM_MAX) ? REM_MAX : i_cnt_m1;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      rem_d   = rem_q;
      last_d  = last_q;

      if (i_deal) begin
         state_d = SEND;
         shreg_d = i_data;
         rem_d   = cnt_clamped;
         last_d  = (cnt_clamped == '0);
      end else if (o_deal) begin
         if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
         end else begin
            shreg_d = shreg_q >> BW;
            rem_d   = rem_q - 1'b1;
            last_d  = (rem_d == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         rem_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_rdy_ack_word_serializer.sv
// Self-checking bench for rdy_ack_word_serializer.
//   A driver pushes the expected {last,byte} sequence of every accepted word
//   into a scoreboard queue; a monitor pops and compares on each output deal.
//   Directed cycle checks cover latency, back-to-back, clamp and reset cases.
module tb_rdy_ack_word_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_rdy, i_ack, o_rdy, o_ack, o_last, busy;
   logic [31:0] i_data;
   logic [1:0]  i_cnt_m1;
   logic [7:0]  o_data;

   // Second instance with a wider count port for the clamp test.
   logic        c_i_rdy, c_i_ack, c_o_rdy, c_o_ack, c_o_last, c_busy;
   logic [31:0] c_i_data;
   logic [2:0]  c_i_cnt_m1;
   logic [7:0]  c_o_data;

   int checks   = 0;
   int failures = 0;
   int words_issued = 0;
   int words_seen   = 0;
   int ack_mode = 0;          // 0: o_ack=1, 1: 1,0,0,1,0,1 pattern, 2: random
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   rdy_ack_word_serializer #(.BW_M1(7), .NB_M1(3), .CW_M1(1)) dut (
      .clk(clk), .rst_n(rst_n), .i_rdy(i_rdy), .i_ack(i_ack),
      .i_data(i_data), .i_cnt_m1(i_cnt_m1), .o_rdy(o_rdy), .o_ack(o_ack),
      .o_data(o_data), .o_last(o_last), .busy(busy)
   );

   rdy_ack_word_serializer #(.BW_M1(7), .NB_M1(3), .CW_M1(2)) dut_clamp (
      .clk(clk), .rst_n(rst_n), .i_rdy(c_i_rdy), .i_ack(c_i_ack),
      .i_data(c_i_data), .i_cnt_m1(c_i_cnt_m1), .o_rdy(c_o_rdy),
      .o_ack(c_o_ack), .o_data(c_o_data), .o_last(c_o_last), .busy(c_busy)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Offer a word; returns one cycle after its handshake with i_rdy still 1.
   task automatic put_word(input logic [31:0] d, input logic [1:0] c);
      bit acked = 1'b0;
      i_data   = d;
      i_cnt_m1 = c;
      i_rdy    = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (i_ack) begin
            acked = 1'b1;
            break;
         end
      end
      if (!acked) begin
         chk("iack_timeout", 32'd0, 32'd1);
         return;
      end
      for (int k = 0; k <= int'(c); k++)
         exp_q.push_back({(k == int'(c)), d[k*8 +: 8]});
      words_issued++;
      tick();
   endtask

   task automatic drain;
      bit done = 1'b0;
      i_rdy = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !o_rdy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
      tick();
   endtask

   // o_ack driver
   initial begin
      int idx = 0;
      logic [5:0] pat = 6'b101001;   // bit i = cycle i: 1,0,0,1,0,1
      o_ack = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ack_mode)
            0:       o_ack = 1'b1;
            1:       begin o_ack = pat[idx]; idx = (idx + 1) % 6; end
            default: o_ack = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Scoreboard monitor
   initial begin
      logic       stall_prev = 1'b0;
      logic [7:0] prev_data  = '0;
      logic       prev_last  = 1'b0;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("hold_data", {24'd0, o_data}, {24'd0, prev_data});
               chk("hold_last", {31'd0, o_last}, {31'd0, prev_last});
            end
            if (o_rdy && !(o_ack && o_last))
               chk("iack_in_send", {31'd0, i_ack}, 32'd0);
            if (o_rdy && o_ack) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_byte", {23'd0, o_last, o_data}, 32'h1ff);
               end else begin
                  e = exp_q.pop_front();
                  chk("byte", {23'd0, o_last, o_data}, {23'd0, e});
                  if (o_last) words_seen++;
               end
            end
            stall_prev = o_rdy && !o_ack;
            prev_data  = o_data;
            prev_last  = o_last;
         end
      end
   end

   initial begin
      logic [7:0] seq1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst_n = 1'b0;
      i_rdy = 1'b0; i_data = '0; i_cnt_m1 = '0;
      c_i_rdy = 1'b0; c_i_data = '0; c_i_cnt_m1 = '0; c_o_ack = 1'b1;
      #12;
      chk("rst_o_rdy",  {31'd0, o_rdy},  32'd0);
      chk("rst_o_data", {24'd0, o_data}, 32'd0);
      chk("rst_o_last", {31'd0, o_last}, 32'd0);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_i_ack",  {31'd0, i_ack},  32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_i_ack", {31'd0, i_ack}, 32'd1);

      // 1: full word, o_ack=1
      put_word(32'h44332211, 2'd3);
      i_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t1_o_rdy",  {31'd0, o_rdy},  32'd1);
         chk("t1_o_data", {24'd0, o_data}, {24'd0, seq1[k]});
         chk("t1_o_last", {31'd0, o_last}, (k == 3) ? 32'd1 : 32'd0);
         tick();
      end
      @(negedge clk);
      chk("t1_idle", {31'd0, o_rdy}, 32'd0);
      tick();

      // 2: short words
      put_word(32'h000000AB, 2'd0);
      i_rdy = 1'b0;
      @(negedge clk);
      chk("t2a_data", {24'd0, o_data}, 32'hAB);
      chk("t2a_last", {31'd0, o_last}, 32'd1);
      tick();
      @(negedge clk);
      chk("t2a_idle", {31'd0, o_rdy}, 32'd0);
      tick();
      put_word(32'hDEAD5A3C, 2'd1);
      i_rdy = 1'b0;
      @(negedge clk);
      chk("t2b_data0", {24'd0, o_data}, 32'h3C);
      tick();
      @(negedge clk);
      chk("t2b_data1", {24'd0, o_data}, 32'h5A);
      chk("t2b_last",  {31'd0, o_last}, 32'd1);
      tick();
      @(negedge clk);
      chk("t2b_idle", {31'd0, o_rdy}, 32'd0);
      tick();

      // 3: back-to-back with no bubble
      fork
         begin
            put_word(32'h04030201, 2'd3);
            put_word(32'h08070605, 2'd3);
            i_rdy = 1'b0;
         end
         begin
            tick();
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               chk("t3_o_rdy",  {31'd0, o_rdy},  32'd1);
               chk("t3_o_data", {24'd0, o_data}, k + 1);
               chk("t3_i_ack",  {31'd0, i_ack},  (k == 3 || k == 7) ? 32'd1 : 32'd0);
               tick();
            end
         end
      join
      drain();

      // 4: backpressure
      ack_mode = 1;
      put_word(32'hA5B6C7D8, 2'd3);
      put_word(32'h00F00E0D, 2'd2);
      drain();
      ack_mode = 0;
      tick();

      // 5: clamp on the wide-count instance
      c_i_data = 32'h44332211; c_i_cnt_m1 = 3'd6; c_i_rdy = 1'b1;
      @(negedge clk);
      chk("t5_i_ack", {31'd0, c_i_ack}, 32'd1);
      tick();
      c_i_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_o_rdy",  {31'd0, c_o_rdy},  32'd1);
         chk("t5_o_data", {24'd0, c_o_data}, {24'd0, seq1[k]});
         chk("t5_o_last", {31'd0, c_o_last}, (k == 3) ? 32'd1 : 32'd0);
         tick();
      end
      @(negedge clk);
      chk("t5_idle", {31'd0, c_o_rdy}, 32'd0);
      tick();

      // 6: reset mid-word
      put_word(32'h44332211, 2'd3);
      i_rdy = 1'b0;
      tick();               // byte 0 taken at this edge
      tick();               // byte 1 taken at this edge
      rst_n = 1'b0;
      #1;
      chk("t6_o_rdy",  {31'd0, o_rdy},  32'd0);
      chk("t6_o_data", {24'd0, o_data}, 32'd0);
      chk("t6_i_ack",  {31'd0, i_ack},  32'd1);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      put_word(32'hA4A3A2A1, 2'd3);
      i_rdy = 1'b0;
      @(negedge clk);
      chk("t6_restart", {24'd0, o_data}, 32'hA1);
      drain();

      // 7: randomized traffic
      words_issued = 0;
      words_seen   = 0;
      ack_mode     = 2;
      for (int w = 0; w < 1000; w++) begin
         put_word($urandom, 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) begin
            i_rdy = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
      end
      drain();
      chk("t7_words", words_seen, words_issued);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
